// File: rtl/divergence_roll_seq_pkg.sv
// Shared types and constants for the divergence-meter roll sequencer.
package divergence_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROLL,
    ST_FINISH
  } state_t;

  localparam int          NUM_DIGITS = 8;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  // Taps x^16 + x^14 + x^13 + x^11 -> state bits 15, 13, 12, 10
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [7:0]  DP_MASK    = 8'h80;

  // The leftmost digit only ever shows 0 or 1; the others fold 10..15 back into 0..5.
  function automatic logic [3:0] draw_digit(input logic [15:0] lfsr, input logic is_msd);
    logic [3:0] r;
    r = lfsr[3:0];
    if (is_msd) return {3'b000, lfsr[4]};
    return (r < 4'd10) ? r : r - 4'd10;
  endfunction

endpackage

// File: rtl/divergence_roll_seq_if.sv
// Button input and digit-display outputs of the roll sequencer.
interface divergence_roll_seq_if;
  logic        botton;
  logic [31:0] digits_o;
  logic [7:0]  dp_o;
  logic        busy_o;
  logic        done_o;

  modport master (input botton, output digits_o, dp_o, busy_o, done_o);
  modport slave  (output botton, input digits_o, dp_o, busy_o, done_o);
endinterface

// File: rtl/divergence_roll_seq_button_debounce.sv
// Synchronizes a raw push-button, accepts a level after DEB_CNT equal samples,
// and emits a one-cycle pulse on each accepted rising edge.
module button_debounce #(
  parameter int DEB_CNT = 20000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

  logic [1:0]    r_sync;
  logic [CW-1:0] r_cnt;
  logic          r_level;
  logic          r_press;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_press <= 1'b0;
      if (r_sync[1] == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEB_CNT - 1)) begin
        r_cnt   <= '0;
        r_level <= r_sync[1];
        r_press <= r_sync[1];
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/divergence_roll_seq.sv
// Divergence-meter roll: scrambles all digits from an LFSR, then locks them
// left to right, one digit every SETTLE_STEPS updates.
module divergence_roll_seq
  import divergence_pkg::*;
#(
  parameter int DEB_CNT      = 20000,
  parameter int ROLL_TICK    = 2500000,
  parameter int SETTLE_STEPS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  divergence_roll_seq_if.master bus
);

  localparam int TW = (ROLL_TICK > 1) ? $clog2(ROLL_TICK) : 1;
  localparam int SW = (SETTLE_STEPS > 1) ? $clog2(SETTLE_STEPS) : 1;

  state_t        r_state, w_next_state;
  logic [TW-1:0] r_tick;
  logic [SW-1:0] r_step;
  logic [2:0]    r_lp;
  logic [31:0]   r_digits;
  logic [15:0]   r_lfsr;
  logic          r_busy;
  logic          r_done;
  logic          w_press;
  logic          w_update;
  logic          w_lock;

  button_debounce #(.DEB_CNT(DEB_CNT)) u_debounce (
    .clk    (clk),
    .rst    (rst),
    .i_btn  (bus.botton),
    .o_press(w_press)
  );

  // NOTE: defaults first keep this block free of inferred latches.
  always_comb begin
    w_next_state = r_state;
    w_update     = (r_state == ST_ROLL) && (r_tick == TW'(ROLL_TICK - 1));
    w_lock       = w_update && (r_step == SW'(SETTLE_STEPS - 1));
    case (r_state)
      ST_IDLE:   if (w_press) w_next_state = ST_ROLL;
      ST_ROLL:   if (w_lock && (r_lp == 3'd0)) w_next_state = ST_FINISH;
      ST_FINISH: w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // Status flags are decoded from the next state so they change with the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state == ST_ROLL);
      r_done  <= (w_next_state == ST_FINISH);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_lfsr   <= LFSR_SEED;
      r_tick   <= '0;
      r_step   <= '0;
      r_lp     <= 3'd7;
      r_digits <= '0;
    end else begin
      r_lfsr <= {r_lfsr[14:0], ^(r_lfsr & LFSR_TAPS)};
      if ((r_state == ST_IDLE) && w_press) begin
        r_tick <= '0;
        r_step <= '0;
        r_lp   <= 3'd7;
      end else if (r_state == ST_ROLL) begin
        if (w_update) begin
          r_tick <= '0;
          // Digits at or right of the lock pointer are still scrambling.
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (3'(i) <= r_lp)
              r_digits[i*4 +: 4] <= draw_digit(r_lfsr, i == NUM_DIGITS - 1);
          end
          if (w_lock) begin
            r_step <= '0;
            r_lp   <= r_lp - 3'd1;
          end else begin
            r_step <= r_step + 1'b1;
          end
        end else begin
          r_tick <= r_tick + 1'b1;
        end
      end
    end
  end

  assign bus.digits_o = r_digits;
  assign bus.dp_o     = DP_MASK;
  assign bus.busy_o   = r_busy;
  assign bus.done_o   = r_done;

endmodule

// File: tb/tb_divergence_roll_seq.sv
// Directed bench for divergence_roll_seq with DEB_CNT=3, ROLL_TICK=4, SETTLE_STEPS=2.
module tb_divergence_roll_seq;
  import divergence_pkg::*;

  localparam int DEB    = 3;
  localparam int TICK   = 4;
  localparam int SETTLE = 2;
  localparam int UPDATES = 8 * SETTLE;

  logic clk = 1'b0;
  logic rst = 1'b0;

  divergence_roll_seq_if bus ();

  divergence_roll_seq #(
    .DEB_CNT     (DEB),
    .ROLL_TICK   (TICK),
    .SETTLE_STEPS(SETTLE)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          errors  = 0;
  int          hold_left = 0;
  bit          range_chk = 1'b0;
  logic [15:0] m_lfsr;
  logic [15:0] pre_lfsr;
  logic [31:0] exp_digits = '0;

  // Independent reference LFSR, reset and clocked alongside the DUT.
  always @(posedge clk or negedge rst) begin
    if (!rst) m_lfsr <= 16'hACE1;
    else      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  function automatic logic [3:0] exp_digit(input logic [15:0] l, input int k);
    if (k == 7) return {3'b000, l[4]};
    return (l[3:0] >= 4'd10) ? l[3:0] - 4'd10 : l[3:0];
  endfunction

  function automatic bit all_bcd(input logic [31:0] d);
    for (int k = 0; k < 8; k++) if (d[k*4 +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    pre_lfsr = m_lfsr;
    @(posedge clk);
    @(negedge clk);
    if (hold_left > 0) begin
      hold_left--;
      if (hold_left == 0) bus.botton = 1'b0;
    end
    if (range_chk) begin
      vectors++;
      if (!all_bcd(bus.digits_o)) begin
        errors++;
        $display("FAIL bcd_range: digits_o=%h required every nibble <= 9", bus.digits_o);
      end
    end
  endtask

  task automatic press(input int hold);
    bus.botton = 1'b1;
    hold_left  = hold;
  endtask

  // One roll from raw press to the cycle after done. Optional: re-press after
  // update repress_u, a press timed to land on FINISH, or reset after update abort_u.
  task automatic do_roll(input int hold, input int repress_u, input bit late, input int abort_u);
    logic [2:0] exp_flags;
    int         lp;
    press(hold);
    for (int i = 1; i <= 6; i++) begin
      tick();
      vectors++;
      exp_flags = {(i == 6), 1'b0, 1'b0};
      if ({bus.busy_o, bus.done_o, 1'b0} !== exp_flags || bus.digits_o !== exp_digits) begin
        errors++;
        $display("FAIL press_latency[%0d]: busy=%b done=%b digits=%h required busy=%b done=0 digits=%h",
                 i, bus.busy_o, bus.done_o, bus.digits_o, (i == 6), exp_digits);
      end
    end
    for (int u = 1; u <= UPDATES; u++) begin
      for (int t = 1; t < TICK; t++) begin
        tick();
        vectors++;
        if (bus.busy_o !== 1'b1 || bus.done_o !== 1'b0 || bus.digits_o !== exp_digits) begin
          errors++;
          $display("FAIL roll_hold u%0d t%0d: busy=%b done=%b digits=%h required busy=1 done=0 digits=%h",
                   u, t, bus.busy_o, bus.done_o, bus.digits_o, exp_digits);
        end
        if (late && u == UPDATES - 1 && t == TICK - 1) press(10);
      end
      tick();
      lp = 7 - (u - 1) / SETTLE;
      for (int k = 0; k <= lp; k++) exp_digits[k*4 +: 4] = exp_digit(pre_lfsr, k);
      vectors++;
      if (bus.digits_o !== exp_digits || bus.busy_o !== (u != UPDATES) || bus.done_o !== (u == UPDATES)) begin
        errors++;
        $display("FAIL update u%0d: digits=%h busy=%b done=%b required digits=%h busy=%b done=%b",
                 u, bus.digits_o, bus.busy_o, bus.done_o, exp_digits, (u != UPDATES), (u == UPDATES));
      end
      if (u == repress_u) press(10);
      if (u == abort_u) begin
        rst = 1'b0;
        #1;
        exp_digits = '0;
        vectors++;
        if (bus.digits_o !== 32'h0 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.dp_o !== 8'h80) begin
          errors++;
          $display("FAIL reset_mid_roll: digits=%h busy=%b done=%b dp=%h required 0/0/0/80",
                   bus.digits_o, bus.busy_o, bus.done_o, bus.dp_o);
        end
        @(negedge clk);
        rst = 1'b1;
        vectors++;
        if (dut.r_state !== ST_IDLE) begin
          errors++;
          $display("FAIL reset_state: state=%0d required IDLE", dut.r_state);
        end
        return;
      end
    end
    tick();
    vectors++;
    if (bus.done_o !== 1'b0 || bus.busy_o !== 1'b0 || bus.digits_o !== exp_digits || exp_digits[31:29] !== 3'b000) begin
      errors++;
      $display("FAIL roll_end: done=%b busy=%b digits=%h required done=0 busy=0 digits=%h msd<=1",
               bus.done_o, bus.busy_o, bus.digits_o, exp_digits);
    end
  endtask

  task automatic idle_check(input string name, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      tick();
      vectors++;
      if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.digits_o !== exp_digits) begin
        errors++;
        $display("FAIL %s[%0d]: busy=%b done=%b digits=%h required busy=0 done=0 digits=%h",
                 name, i, bus.busy_o, bus.done_o, bus.digits_o, exp_digits);
      end
    end
  endtask

  task automatic test_reset();
    bus.botton = 1'b0;
    rst = 1'b0;
    #12;
    vectors++;
    if (bus.digits_o !== 32'h0 || bus.dp_o !== 8'h80 || bus.busy_o !== 1'b0 || bus.done_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: digits=%h dp=%h busy=%b done=%b required 0/80/0/0",
               bus.digits_o, bus.dp_o, bus.busy_o, bus.done_o);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      vectors++;
      if (bus.digits_o !== 32'h0 || bus.dp_o !== 8'h80 || bus.busy_o !== 1'b0) begin
        errors++;
        $display("FAIL idle_outputs[%0d]: digits=%h dp=%h busy=%b required 0/80/0",
                 i, bus.digits_o, bus.dp_o, bus.busy_o);
      end
    end
  endtask

  task automatic test_lfsr_period();
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    vectors++;
    if (dut.r_lfsr !== 16'hACE1) begin
      errors++;
      $display("FAIL lfsr_seed: lfsr=%h required ace1", dut.r_lfsr);
    end
    tick();
    vectors++;
    if (dut.r_lfsr !== 16'h59C3) begin
      errors++;
      $display("FAIL lfsr_step1: lfsr=%h required 59c3", dut.r_lfsr);
    end
    for (int i = 1; i < 65535; i++) tick();
    vectors++;
    if (dut.r_lfsr !== 16'hACE1) begin
      errors++;
      $display("FAIL lfsr_period: lfsr=%h required ace1", dut.r_lfsr);
    end
  endtask

  task automatic test_glitch();
    press(2);
    idle_check("glitch", 20);
  endtask

  task automatic test_full_roll();
    do_roll(40, 0, 1'b0, 0);
    idle_check("after_full", 10);
  endtask

  task automatic test_repress();
    do_roll(10, 5, 1'b0, 0);
    idle_check("no_second_roll", 20);
  endtask

  task automatic test_press_at_finish();
    do_roll(10, 0, 1'b1, 0);
    idle_check("finish_press_dropped", 20);
  endtask

  task automatic test_reset_mid_roll();
    do_roll(10, 0, 1'b0, 7);
    idle_check("after_abort", 5);
    do_roll(10, 0, 1'b0, 0);
  endtask

  task automatic test_back_to_back();
    range_chk = 1'b1;
    for (int n = 0; n < 200; n++) do_roll(10, 0, 1'b0, 0);
    range_chk = 1'b0;
  endtask

  initial begin
    bus.botton = 1'b0;
    test_reset();
    test_lfsr_period();
    test_glitch();
    test_full_roll();
    test_repress();
    test_press_at_finish();
    test_reset_mid_roll();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
